dbgnoc_conf_regs: RTL and testbench
===================================

# dbgnoc_conf_regs

Parametrised configuration-register endpoint for the debug NoC. It replaces the fixed single-word, load-only configuration interface with a `MEM_SIZE`-deep register file that can be read and written over the NoC in bursts. The register file has a read-only region supplied by the debug module and a writable region driven back into the module, and the endpoint answers read requests with response packets. It sits between a debug module (for example the debug processor) and its debug NoC router port.

## Interface
Parameters:
- `DBG_NOC_FLIT_DATA_WIDTH`, 16, flit payload width; register width equals this.
- `DBG_NOC_FLIT_TYPE_WIDTH`, 2, flit type field width.
- `MEM_SIZE`, 8, number of registers; must be at most 256.
- `RO_SIZE`, 2, registers 0..`RO_SIZE`-1 are read-only; must be at least 1.
- `MODULE_TYPE`, 8'h06, upper byte of register 0.
- `MODULE_VERSION`, 8'h01, lower byte of register 0.
- `NODE_ID`, 5'd0, this endpoint's NoC address.

Ports (clk and reset first; `FW` = type width + data width, `DW` = data width):
- `clk`  in  1  single clock, all logic posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `dbgnoc_conf_in_flit`  in  FW  request flit, `{type, data}`.
- `dbgnoc_conf_in_valid`  in  1  request flit valid.
- `dbgnoc_conf_in_ready`  out  1  endpoint accepts flit.
- `dbgnoc_conf_out_flit`  out  FW  response flit.
- `dbgnoc_conf_out_valid`  out  1  response flit valid.
- `dbgnoc_conf_out_ready`  in  1  router accepts flit.
- `conf_ro_flat_in`  in  `RO_SIZE`×DW  values for registers 1..`RO_SIZE`-1; the slice for index 0 is ignored.
- `conf_ro_flat_in_valid`  in  `RO_SIZE`  per-register load strobe.
- `conf_rw_flat_out`  out  `MEM_SIZE`×DW  current register contents.
- `conf_rw_flat_out_wr`  out  `MEM_SIZE`  one-cycle strobe per NoC-written register.

## Operation
- Flit types: `01` HEAD, `00` BODY, `10` LAST, `11` SINGLE.
- Head data layout: [15:11] destination, [10:8] class, [4:0] source.
- Classes: 0 = READ, 1 = WRITE, 2 = RESPONSE.
- WRITE packet: HEAD, then an address flit (bits [7:0]), then one or more data flits, the final one of type LAST.
  - Each data flit writes the current address, then the address increments.
- READ packet: HEAD, then an address flit, then a LAST flit carrying the count N in bits [7:0]. N=0 is treated as 1.
- Read response: HEAD `{src_of_request, 3'd2, 3'b0, NODE_ID}`, then N data flits from addr, addr+1, and so on.
  - The final flit has type LAST. If N=1 the data flit is LAST and there is no SINGLE flit.
- Address out of range (addr ≥ `MEM_SIZE`, including wrap past 255): writes are dropped and reads return 0. Address arithmetic is 8-bit, wrapping 255→0.
- Writes to addr < `RO_SIZE` are ignored; no `_wr` strobe is generated.
- Register 0 is always `{MODULE_TYPE, MODULE_VERSION}`.
- `conf_ro_flat_in_valid[i]` (i ≥ 1) loads register i on the next edge.
- Packets that cannot be handled are drained to their LAST flit and produce no response or state change:
  - unknown class;
  - a SINGLE flit;
  - a READ with no count flit (address flit already typed LAST).
- A WRITE whose address flit is LAST performs no write.
- FSM states:
  - IDLE: HEAD → ADDR. Any other type is discarded, staying in IDLE except on a non-final flit → DROP.
  - ADDR: → WDATA or RCNT.
  - WDATA: LAST → IDLE.
  - RCNT → RHDR → RDATA → IDLE.
  - DROP: LAST → IDLE.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_flit`=0, `_wr`=0.
  - Registers 1..`MEM_SIZE`-1 reset to 0; register 0 holds the constant.
  - FSM resets to IDLE.
- `in_ready`=1 in IDLE, ADDR, WDATA, RCNT and DROP; 0 in RHDR and RDATA.
- A flit transfers when valid && ready.
- A write takes effect and its `_wr` strobe pulses on the edge after the data flit is accepted (1-cycle latency).
- If a NoC write and a `ro_in_valid` load hit the same register in the same cycle, the NoC write wins. This cannot occur for read-only registers because they are not NoC-writable.
- Response head is valid the cycle after the count flit is accepted. Each data flit follows one cycle after the previous one is accepted.
- `out_flit` and `out_valid` are registered and held stable while `out_ready`=0.
- Read data is sampled when each flit is presented.
- Reset asserted mid-packet aborts the packet. Subsequent input flits are handled from IDLE (drop to LAST).

## Structure
- Shared package `dbgnoc_pkg` holds:
  - flit type codes;
  - class codes;
  - head-field bit positions;
  - the FSM state enum.
- One natural sub-module: `dbgnoc_conf_regfile`, holding register storage, the read mux, load/write arbitration and the `_wr` strobes. The FSM and packetiser stay in the top.

## Test plan
- Reset released, READ addr 0 N=1 from src 3 → HEAD `{5'd3,3'd2,3'b0,NODE_ID}`, then LAST 16'h0601.
- WRITE addr 2, data A5A5 (BODY), 5A5A (LAST), then READ addr 2 N=2 → response returns A5A5, 5A5A. `_wr[2]` and `_wr[3]` each pulse one cycle.
- WRITE to addr 0 and addr 1 → no `_wr`. Register 1 keeps the value loaded via `ro_in_valid[1]` (1234); read back returns 1234.
- READ addr 6 N=4 with `MEM_SIZE`=8 → data reg6, reg7, 0, 0; the 4th flit is LAST.
- `out_ready` held 0 for 5 cycles mid-response → flit stable, no loss or duplication, and `in_ready` stays 0.
- Class-5 packet of 3 flits, then a valid READ → first packet dropped silently, READ answered normally. Assert `rst` mid-WRITE → all outputs return to reset values immediately.

Source files
------------

// File: rtl/dbgnoc_pkg.sv
// Shared debug NoC definitions: flit types, packet classes, head field positions
// and the configuration endpoint FSM states.
package dbgnoc_pkg;

  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_LAST   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  localparam logic [2:0] CLASS_READ     = 3'd0;
  localparam logic [2:0] CLASS_WRITE    = 3'd1;
  localparam logic [2:0] CLASS_RESPONSE = 3'd2;

  localparam int HEAD_DST_MSB   = 15;
  localparam int HEAD_DST_LSB   = 11;
  localparam int HEAD_CLASS_MSB = 10;
  localparam int HEAD_CLASS_LSB = 8;
  localparam int HEAD_SRC_MSB   = 4;
  localparam int HEAD_SRC_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_RCNT,
    ST_RHDR,
    ST_RDATA,
    ST_DROP
  } conf_state_t;

endpackage

// File: rtl/dbgnoc_conf_regfile.sv
// Configuration register storage: constant id word, module-loaded read-only
// registers and NoC-written registers. Writes and strobes land one edge after wr_en.
module dbgnoc_conf_regfile #(
  parameter int             DW       = 16,
  parameter int             MEM_SIZE = 8,
  parameter int             RO_SIZE  = 2,
  parameter logic [DW-1:0]  REG0     = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_addr,
  input  logic [DW-1:0]          wr_data,
  input  logic [7:0]             rd_addr,
  output logic [DW-1:0]          rd_data,
  input  logic [RO_SIZE*DW-1:0]  ro_data,
  input  logic [RO_SIZE-1:0]     ro_valid,
  output logic [MEM_SIZE*DW-1:0] regs_flat,
  output logic [MEM_SIZE-1:0]    regs_wr
);

  logic [DW-1:0]       regs_q [MEM_SIZE];
  logic [MEM_SIZE-1:0] wr_q;
  logic                unused_ro;

  // Register 0 is the id word, so its load slice and strobe have no effect.
  assign unused_ro = ^{ro_data[DW-1:0], ro_valid[0]};

  // Read-only and writable index ranges are disjoint, so a NoC write never
  // competes with a module load on the same register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_SIZE; i++) regs_q[i] <= '0;
      regs_q[0] <= REG0;
      wr_q      <= '0;
    end else begin
      wr_q      <= '0;
      regs_q[0] <= REG0;
      for (int i = 1; i < RO_SIZE; i++) begin
        if (ro_valid[i]) regs_q[i] <= ro_data[i*DW +: DW];
      end
      for (int i = RO_SIZE; i < MEM_SIZE; i++) begin
        if (wr_en && wr_addr == 8'(i)) begin
          regs_q[i] <= wr_data;
          wr_q[i]   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < MEM_SIZE; i++) begin
      if (rd_addr == 8'(i)) rd_data = regs_q[i];
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < MEM_SIZE; i++) regs_flat[i*DW +: DW] = regs_q[i];
  end

  assign regs_wr = wr_q;

endmodule

// File: rtl/dbgnoc_conf_regs.sv
// Debug NoC configuration endpoint: burst read/write of a register file, reads
// answered with a registered response packet; input stalls while a response streams.
module dbgnoc_conf_regs
  import dbgnoc_pkg::*;
#(
  parameter int          DBG_NOC_FLIT_DATA_WIDTH = 16,
  parameter int          DBG_NOC_FLIT_TYPE_WIDTH = 2,
  parameter int          MEM_SIZE                = 8,
  parameter int          RO_SIZE                 = 2,
  parameter logic [7:0]  MODULE_TYPE             = 8'h06,
  parameter logic [7:0]  MODULE_VERSION          = 8'h01,
  parameter logic [4:0]  NODE_ID                 = 5'd0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [DBG_NOC_FLIT_TYPE_WIDTH+DBG_NOC_FLIT_DATA_WIDTH-1:0] dbgnoc_conf_in_flit,
  input  logic                                          dbgnoc_conf_in_valid,
  output logic                                          dbgnoc_conf_in_ready,
  output logic [DBG_NOC_FLIT_TYPE_WIDTH+DBG_NOC_FLIT_DATA_WIDTH-1:0] dbgnoc_conf_out_flit,
  output logic                                          dbgnoc_conf_out_valid,
  input  logic                                          dbgnoc_conf_out_ready,
  input  logic [RO_SIZE*DBG_NOC_FLIT_DATA_WIDTH-1:0]    conf_ro_flat_in,
  input  logic [RO_SIZE-1:0]                            conf_ro_flat_in_valid,
  output logic [MEM_SIZE*DBG_NOC_FLIT_DATA_WIDTH-1:0]   conf_rw_flat_out,
  output logic [MEM_SIZE-1:0]                           conf_rw_flat_out_wr
);

  localparam int DW = DBG_NOC_FLIT_DATA_WIDTH;
  localparam int TW = DBG_NOC_FLIT_TYPE_WIDTH;
  localparam int FW = TW + DW;

  localparam logic [TW-1:0] T_BODY = TW'(FLIT_BODY);
  localparam logic [TW-1:0] T_HEAD = TW'(FLIT_HEAD);
  localparam logic [TW-1:0] T_LAST = TW'(FLIT_LAST);

  conf_state_t   state_q, state_d;
  logic [TW-1:0] in_type;
  logic [DW-1:0] in_dat;
  logic          in_xfer, out_xfer;
  logic          in_ready_q, in_ready_d;
  logic          wr_en;
  logic [2:0]    cls_q;
  logic [4:0]    src_q;
  logic [7:0]    addr_q, cnt_q;
  logic [FW-1:0] out_flit_q;
  logic          out_valid_q;
  logic [DW-1:0] rd_data;

  assign in_type  = dbgnoc_conf_in_flit[FW-1:DW];
  assign in_dat   = dbgnoc_conf_in_flit[DW-1:0];
  assign in_xfer  = dbgnoc_conf_in_valid && in_ready_q;
  assign out_xfer = out_valid_q && dbgnoc_conf_out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_xfer) begin
        if (in_type == T_HEAD)      state_d = ST_ADDR;
        else if (in_type == T_BODY) state_d = ST_DROP;
      end
      ST_ADDR: if (in_xfer) begin
        // An address flit that already ends the packet leaves nothing to do.
        if (in_type == T_LAST)           state_d = ST_IDLE;
        else if (cls_q == CLASS_WRITE)   state_d = ST_WDATA;
        else if (cls_q == CLASS_READ)    state_d = ST_RCNT;
        else                             state_d = ST_DROP;
      end
      ST_WDATA: if (in_xfer && in_type == T_LAST) state_d = ST_IDLE;
      ST_RCNT:  if (in_xfer) state_d = (in_type == T_LAST) ? ST_RHDR : ST_DROP;
      ST_RHDR:  if (out_xfer) state_d = ST_RDATA;
      ST_RDATA: if (out_xfer && cnt_q == 8'd0) state_d = ST_IDLE;
      ST_DROP:  if (in_xfer && in_type == T_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_d = !(state_d == ST_RHDR || state_d == ST_RDATA);
    wr_en      = (state_q == ST_WDATA) && in_xfer;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in_ready_q <= 1'b0;
    else      in_ready_q <= in_ready_d;
  end

  // cnt_q counts response data flits still to be presented after the current one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cls_q       <= '0;
      src_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      out_flit_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && in_xfer && in_type == T_HEAD) begin
        cls_q <= in_dat[HEAD_CLASS_MSB:HEAD_CLASS_LSB];
        src_q <= in_dat[HEAD_SRC_MSB:HEAD_SRC_LSB];
      end
      if (state_q == ST_ADDR && in_xfer) addr_q <= in_dat[7:0];
      if (wr_en) addr_q <= addr_q + 8'd1;
      if (state_q == ST_RCNT && in_xfer && in_type == T_LAST) begin
        cnt_q       <= (in_dat[7:0] == 8'd0) ? 8'd1 : in_dat[7:0];
        out_flit_q  <= {T_HEAD, DW'({src_q, CLASS_RESPONSE, 3'b000, NODE_ID})};
        out_valid_q <= 1'b1;
      end
      if (out_xfer && (state_q == ST_RHDR || state_q == ST_RDATA)) begin
        if (state_q == ST_RDATA && cnt_q == 8'd0) begin
          out_valid_q <= 1'b0;
        end else begin
          out_flit_q <= {(cnt_q == 8'd1) ? T_LAST : T_BODY, rd_data};
          addr_q     <= addr_q + 8'd1;
          cnt_q      <= cnt_q - 8'd1;
        end
      end
    end
  end

  dbgnoc_conf_regfile #(
    .DW       (DW),
    .MEM_SIZE (MEM_SIZE),
    .RO_SIZE  (RO_SIZE),
    .REG0     (DW'({MODULE_TYPE, MODULE_VERSION}))
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (addr_q),
    .wr_data   (in_dat),
    .rd_addr   (addr_q),
    .rd_data   (rd_data),
    .ro_data   (conf_ro_flat_in),
    .ro_valid  (conf_ro_flat_in_valid),
    .regs_flat (conf_rw_flat_out),
    .regs_wr   (conf_rw_flat_out_wr)
  );

  assign dbgnoc_conf_in_ready  = in_ready_q;
  assign dbgnoc_conf_out_flit  = out_flit_q;
  assign dbgnoc_conf_out_valid = out_valid_q;

endmodule

// File: tb/tb_dbgnoc_conf_regs.sv
// Scoreboard bench for dbgnoc_conf_regs: expected response flits are queued as
// requests are issued and a monitor compares each accepted output flit.
module tb_dbgnoc_conf_regs;

  localparam logic [4:0] NODE = 5'd7;
  localparam logic [1:0] B = 2'b00, H = 2'b01, L = 2'b10;

  logic         clk = 1'b0;
  logic         rst;
  logic [17:0]  in_flit;
  logic         in_valid;
  logic         in_ready;
  logic [17:0]  out_flit;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  ro_flat;
  logic [1:0]   ro_valid;
  logic [127:0] rw_flat;
  logic [7:0]   rw_wr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [17:0] exp_q[$];
  int wr_hi [8];
  int exp_wr[8];

  always #5 clk = ~clk;

  dbgnoc_conf_regs #(
    .DBG_NOC_FLIT_DATA_WIDTH (16),
    .DBG_NOC_FLIT_TYPE_WIDTH (2),
    .MEM_SIZE                (8),
    .RO_SIZE                 (2),
    .MODULE_TYPE             (8'h06),
    .MODULE_VERSION          (8'h01),
    .NODE_ID                 (NODE)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .dbgnoc_conf_in_flit   (in_flit),
    .dbgnoc_conf_in_valid  (in_valid),
    .dbgnoc_conf_in_ready  (in_ready),
    .dbgnoc_conf_out_flit  (out_flit),
    .dbgnoc_conf_out_valid (out_valid),
    .dbgnoc_conf_out_ready (out_ready),
    .conf_ro_flat_in       (ro_flat),
    .conf_ro_flat_in_valid (ro_valid),
    .conf_rw_flat_out      (rw_flat),
    .conf_rw_flat_out_wr   (rw_wr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] rsp_head(input logic [4:0] src);
    return {H, src, 3'd2, 3'b000, NODE};
  endfunction

  function automatic logic [15:0] req_head(input logic [2:0] cls, input logic [4:0] src);
    return {NODE, cls, 3'b000, src};
  endfunction

  // Monitor: output flits against the scoreboard, write strobes into counters.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_flit: got %h expected none", out_flit);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          if (out_flit !== e) begin
            n_fail++;
            $display("FAIL rsp_flit: got %h expected %h", out_flit, e);
          end
        end
      end
      for (int i = 0; i < 8; i++) if (rw_wr[i]) wr_hi[i]++;
    end
  end

  task automatic send(input logic [1:0] t, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    in_flit  = {t, d};
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic read_req(input logic [4:0] src, input logic [7:0] addr, input logic [7:0] n);
    send(H, req_head(3'd0, src));
    send(B, {8'h00, addr});
    send(L, {8'h00, n});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_wr(input string name);
    for (int i = 0; i < 8; i++) check(name, wr_hi[i], exp_wr[i]);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      wr_hi[i]  = 0;
      exp_wr[i] = 0;
    end
    rst = 1'b0; in_flit = '0; in_valid = 1'b0; out_ready = 1'b1;
    ro_flat = '0; ro_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_flit", 32'(out_flit), 32'd0);
    check("rst_wr", 32'(rw_wr), 32'd0);
    check("rst_reg0", 32'(rw_flat[15:0]), 32'h0601);
    check("rst_regs_hi", rw_flat[127:96], 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Load register 1; the slice for register 0 must be ignored.
    ro_flat = {16'h1234, 16'hdead}; ro_valid = 2'b11;
    @(posedge clk); #1 ro_valid = 2'b00;
    @(negedge clk);
    check("ro_load_reg1", 32'(rw_flat[31:16]), 32'h1234);
    check("ro_reg0_const", 32'(rw_flat[15:0]), 32'h0601);

    exp_q.push_back(rsp_head(5'd3));
    exp_q.push_back({L, 16'h0601});
    read_req(5'd3, 8'd0, 8'd1);
    wait_drain("drain_read_id");

    send(H, req_head(3'd1, 5'd3));
    send(B, 16'h0002);
    send(B, 16'hA5A5);
    send(L, 16'h5A5A);
    exp_wr[2]++; exp_wr[3]++;
    repeat (3) @(negedge clk);
    check("wr_reg2", 32'(rw_flat[47:32]), 32'hA5A5);
    check("wr_reg3", 32'(rw_flat[63:48]), 32'h5A5A);
    check_wr("wr_strobe_2_3");

    exp_q.push_back(rsp_head(5'd3));
    exp_q.push_back({B, 16'hA5A5});
    exp_q.push_back({L, 16'h5A5A});
    read_req(5'd3, 8'd2, 8'd2);
    wait_drain("drain_read_2");

    send(H, req_head(3'd1, 5'd2));
    send(B, 16'h0000);
    send(B, 16'h1111);
    send(L, 16'h2222);
    repeat (3) @(negedge clk);
    check_wr("wr_ro_ignored");
    check("ro_reg1_kept", 32'(rw_flat[31:16]), 32'h1234);
    exp_q.push_back(rsp_head(5'd2));
    exp_q.push_back({L, 16'h1234});
    read_req(5'd2, 8'd1, 8'd1);
    wait_drain("drain_read_ro");

    send(H, req_head(3'd1, 5'd1));
    send(B, 16'h0006);
    send(B, 16'h6666);
    send(L, 16'h7777);
    exp_wr[6]++; exp_wr[7]++;
    exp_q.push_back(rsp_head(5'd1));
    exp_q.push_back({B, 16'h6666});
    exp_q.push_back({B, 16'h7777});
    exp_q.push_back({B, 16'h0000});
    exp_q.push_back({L, 16'h0000});
    read_req(5'd1, 8'd6, 8'd4);
    wait_drain("drain_read_oob");
    check_wr("wr_strobe_6_7");

    // Backpressure in the middle of a response.
    @(posedge clk); #1 out_ready = 1'b0;
    exp_q.push_back(rsp_head(5'd5));
    exp_q.push_back({B, 16'hA5A5});
    exp_q.push_back({B, 16'h5A5A});
    exp_q.push_back({L, 16'h0000});
    read_req(5'd5, 8'd2, 8'd3);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      check("stall_rsp_seen", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_flit", 32'(out_flit), 32'(exp_q[0]));
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain("drain_stall");

    // Unknown class is drained silently, then a normal read.
    send(H, req_head(3'd5, 5'd4));
    send(B, 16'h0003);
    send(L, 16'h0001);
    exp_q.push_back(rsp_head(5'd4));
    exp_q.push_back({L, 16'h1234});
    read_req(5'd4, 8'd1, 8'd1);
    wait_drain("drain_after_drop");
    check_wr("wr_after_drop");

    // Reset in the middle of a write packet.
    send(H, req_head(3'd1, 5'd6));
    send(B, 16'h0004);
    send(B, 16'h4444);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_flit", 32'(out_flit), 32'd0);
    check("midrst_wr", 32'(rw_wr), 32'd0);
    check("midrst_reg4", 32'(rw_flat[79:64]), 32'd0);
    check("midrst_reg1", 32'(rw_flat[31:16]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    send(L, 16'h9999);
    repeat (3) @(negedge clk);
    check("postrst_reg4", 32'(rw_flat[79:64]), 32'd0);
    check("postrst_reg5", 32'(rw_flat[95:80]), 32'd0);
    check_wr("wr_postrst");
    exp_q.push_back(rsp_head(5'd1));
    exp_q.push_back({L, 16'h0601});
    read_req(5'd1, 8'd0, 8'd0);
    wait_drain("drain_postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
